// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared definitions for the binary-to-BCD front end of the
//                7-segment display path: digit width, BCD constants, FSM
//                state encoding and a power-of-ten helper used to derive the
//                saturation limit at elaboration time.
//  Contents    : DIGIT_W, BCD_NINE, state_t {IDLE, SHIFT}, pow10()
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_NINE = 4'h9;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Elaboration-time 10^n; only ever called with constant arguments.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq_if
//  Description : Start/done handshake bundle between a binary count source
//                (master) and the sequential binary-to-BCD converter (slave).
//  Signals     : start    - conversion request (master -> slave)
//                bin_in   - binary value, BIN_W bits (master -> slave)
//                busy     - conversion in progress (slave -> master)
//                done     - one-cycle result strobe (slave -> master)
//                bcd_out  - packed BCD, digit 0 in [3:0] (slave -> master)
//                overflow - last conversion saturated (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bin2bcd_seq_if
  import seg_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
);

  logic                      start;
  logic [BIN_W-1:0]          bin_in;
  logic                      busy;
  logic                      done;
  logic [DIGIT_W*DIGITS-1:0] bcd_out;
  logic                      overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );

endinterface
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Double-dabble digit correction: a 4-bit BCD digit that is 5
//                or more gets 3 added so the following left shift carries
//                correctly into the next decimal digit. Purely combinational,
//                4 bits wide, never produces a carry out.
//  Ports       : din  - scratch digit before correction
//                dout - corrected digit
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3
  import seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential binary-to-BCD converter (shift-and-add-3). One
//                shift per clock; a conversion takes BIN_W cycles from the
//                accepting edge to the done pulse. Inputs above 10^DIGITS-1
//                saturate to all nines and raise overflow.
//  Ports       : sys_clk  - system clock
//                sys_rst  - asynchronous active-high reset
//                bus      - bin2bcd_seq_if slave: start, bin_in, busy,
//                           done, bcd_out, overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam int SCR_W = DIGIT_W * DIGITS;

  // Largest representable value, widened to BIN_W+1 bits. If the decimal
  // limit does not fit in that width no input can exceed it, so clamp to
  // all ones rather than letting truncation create false overflows.
  localparam longint unsigned LIMIT_FULL = pow10(DIGITS) - 64'd1;
  localparam logic [BIN_W:0]  OVF_LIMIT  =
    (LIMIT_FULL < (64'd1 << (BIN_W + 1))) ? LIMIT_FULL[BIN_W:0] : '1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  // --------------------------------------------------------------------------
  // Datapath / FSM storage
  // --------------------------------------------------------------------------
  state_t              state;
  state_t              state_nxt;
  logic [BIN_W-1:0]    shreg;
  logic [SCR_W-1:0]    scratch;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_pend;
  logic [SCR_W-1:0]    bcd_reg;
  logic                ovf_reg;
  logic                done_reg;

  // FSM decoded controls
  logic                busy_c;
  logic                load_c;
  logic                shift_c;
  logic                last_c;

  // Corrected scratch and the value it becomes after this edge's shift
  logic [SCR_W-1:0]    corr;
  logic [SCR_W-1:0]    scratch_shifted;
  logic [SCR_W-1:0]    all_nines;

  // --------------------------------------------------------------------------
  // Per-digit add-3 correction
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[gi*DIGIT_W +: DIGIT_W]),
      .dout (corr[gi*DIGIT_W +: DIGIT_W])
    );
  end

  assign scratch_shifted = {corr[SCR_W-2:0], shreg[BIN_W-1]};
  assign all_nines       = {DIGITS{BCD_NINE}};
  assign last_c          = (cnt == LAST_CNT);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last_c)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode
  // --------------------------------------------------------------------------
  always_comb begin
    busy_c  = 1'b0;
    load_c  = 1'b0;
    shift_c = 1'b0;
    case (state)
      IDLE: begin
        load_c = bus.start;
      end
      SHIFT: begin
        busy_c  = 1'b1;
        shift_c = 1'b1;
      end
      default: begin
        busy_c = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bcd_reg  <= '0;
      ovf_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (load_c) begin
        shreg    <= bus.bin_in;
        scratch  <= '0;
        cnt      <= '0;
        ovf_pend <= ({1'b0, bus.bin_in} > OVF_LIMIT);
      end else if (shift_c) begin
        shreg   <= {shreg[BIN_W-2:0], 1'b0};
        scratch <= scratch_shifted;
        cnt     <= cnt + 1'b1;
        if (last_c) begin
          // Final shift: publish straight from the shifted value so the
          // result is visible in the same cycle as done.
          bcd_reg  <= ovf_pend ? all_nines : scratch_shifted;
          ovf_reg  <= ovf_pend;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_reg;
  assign bus.bcd_out  = bcd_reg;
  assign bus.overflow = ovf_reg;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_seq
//  Description : Self-checking bench for bin2bcd_seq. An independent timing
//                model tracks acceptance and the expected busy/done pattern;
//                expected results (decimal digits via divide/modulo) are
//                queued at acceptance and compared when done rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

  localparam int BIN_W  = 20;
  localparam int DIGITS = 6;
  localparam int PERIOD = BIN_W + 1;

  logic sys_clk;
  logic sys_rst;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // {overflow, bcd} computed by decimal division
  function automatic logic [24:0] ref_conv(input int unsigned v);
    logic [24:0]  r;
    int unsigned  x;
    r = '0;
    if (v > 999999) begin
      r = {1'b1, 24'h999999};
    end else begin
      x = v;
      for (int d = 0; d < DIGITS; d++) begin
        r[4*d +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Timing model and scoreboard
  // --------------------------------------------------------------------------
  logic [24:0] sb[$];
  int          mcnt;
  logic        exp_done;
  int          n_acc;
  int          n_done;
  int          cyc;
  logic        b2b;
  int          b2b_cnt;
  int          prev_done;
  logic [24:0] held;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mcnt     <= 0;
      exp_done <= 1'b0;
      sb.delete();
    end else begin
      exp_done <= (mcnt == 1);
      if (mcnt == 0) begin
        if (bus.start) begin
          mcnt <= BIN_W;
          sb.push_back(ref_conv(32'(bus.bin_in)));
          n_acc <= n_acc + 1;
        end
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      held <= '0;
    end else begin
      chk("busy", 32'(bus.busy), 32'(mcnt != 0));
      chk("done", 32'(bus.done), 32'(exp_done));
      if (!b2b) b2b_cnt <= 0;
      if (bus.done) begin
        n_done <= n_done + 1;
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          chk("bcd", 32'(bus.bcd_out), 32'(sb[0][23:0]));
          chk("ovf", 32'(bus.overflow), 32'(sb[0][24]));
          held <= sb[0];
          void'(sb.pop_front());
        end
        if (b2b) begin
          if (b2b_cnt > 0) chk("period", 32'(cyc - prev_done), 32'(PERIOD));
          b2b_cnt <= b2b_cnt + 1;
        end
        prev_done <= cyc;
      end else begin
        chk("hold_bcd", 32'(bus.bcd_out), 32'(held[23:0]));
        chk("hold_ovf", 32'(bus.overflow), 32'(held[24]));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic wait_idle();
    int n = 0;
    while ((mcnt != 0 || exp_done || sb.size() != 0) && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 200) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input int unsigned v);
    wait_idle();
    @(negedge sys_clk);
    bus.start  = 1'b1;
    bus.bin_in = BIN_W'(v);
    @(negedge sys_clk);
    bus.start  = 1'b0;
    wait_idle();
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    n_acc     = 0;
    n_done    = 0;
    cyc       = 0;
    b2b       = 1'b0;
    b2b_cnt   = 0;
    prev_done = 0;
    sys_rst    = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_bcd",  32'(bus.bcd_out), 32'd0);
    chk("rst_ovf",  32'(bus.overflow), 32'd0);
    sys_rst = 1'b0;

    run(0);
    run(60);
    run(999999);
    run(1048575);
    run(123456);

    // start held high with a moving bin_in: acceptance on every done cycle
    wait_idle();
    b2b = 1'b1;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      @(negedge sys_clk);
      bus.start  = 1'b1;
      bus.bin_in = BIN_W'($urandom_range(0, 1048575));
    end
    @(negedge sys_clk);
    bus.start = 1'b0;
    wait_idle();
    b2b = 1'b0;

    // asynchronous reset in the middle of a conversion of 54321
    @(negedge sys_clk);
    bus.start  = 1'b1;
    bus.bin_in = BIN_W'(54321);
    @(posedge sys_clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("mid_rst_bcd",  32'(bus.bcd_out), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    @(negedge sys_clk);
    #2 sys_rst = 1'b0;
    n_acc  = 0;
    n_done = 0;
    repeat (2 * PERIOD) @(negedge sys_clk);
    chk("mid_rst_nodone", 32'(n_done), 32'd0);
    run(54321);

    // randomised sweep with ignored starts sprinkled in while busy
    for (int i = 0; i < 1000; i++) begin
      wait_idle();
      @(negedge sys_clk);
      bus.start  = 1'b1;
      bus.bin_in = BIN_W'($urandom_range(0, 999999));
      @(negedge sys_clk);
      bus.start  = 1'b0;
      repeat ($urandom_range(0, 15)) @(negedge sys_clk);
      bus.start  = 1'b1;
      bus.bin_in = BIN_W'($urandom_range(0, 1048575));
      @(negedge sys_clk);
      bus.start  = 1'b0;
      wait_idle();
    end

    repeat (3) @(negedge sys_clk);
    chk("done_count", 32'(n_done), 32'(n_acc));
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly upstream of the dynamic 7-segment scan driver and turns a binary count value into packed BCD digits, one digit per display position. It replaces a combinational divide/modulo chain with one shift per clock, and uses a start/done handshake so the count source can run at any rate.

Parameters:
BIN_W, 20, width of the binary input in bits (at least 4).
DIGITS, 6, number of BCD output digits. This is the number of display positions.

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst  input  1  reset; asynchronous, active-high
start  input  1  conversion request, sampled only in IDLE
bin_in  input  BIN_W  binary value, captured in the cycle start is accepted
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd_out and overflow are updated
bcd_out  output  4*DIGITS  packed BCD; digit 0 in [3:0], most significant digit in the top nibble
overflow  output  1  last conversion saturated

Behaviour:
- Reset values: sys_rst high forces all of the following immediately, independent of the clock:
  - state = IDLE
  - busy = 0, done = 0, overflow = 0, bcd_out = 0
  - shift counter = 0, scratch registers = 0
- Reset mid-conversion: the conversion is abandoned, no done pulse is produced, and bcd_out returns to 0.
- States and transitions:
  - IDLE: busy = 0. If start = 1 at a clock edge:
    - capture bin_in into the shift register and clear the BCD scratch;
    - set the shift counter to 0 and latch ovf_pend = (bin_in > 10^DIGITS − 1);
    - go to SHIFT.
  - SHIFT: busy = 1. Each edge does the following:
    - every 4-bit scratch digit ≥ 5 gets +3 (combinational correction);
    - then {scratch, shift register} shifts left by 1;
    - the counter increments.
  - SHIFT exit: on the edge where the counter equals BIN_W−1 (the final shift), the block registers the outputs, pulses done, and goes to IDLE:
    - bcd_out = corrected and shifted scratch, or all nibbles 4'h9 if ovf_pend;
    - overflow = ovf_pend;
    - done = 1.
- done: high for exactly one cycle, the cycle after the final shift edge. That cycle is an IDLE cycle, so a start asserted during it is accepted. Back-to-back conversions therefore have a period of BIN_W+1 cycles.
- Latency: start sampled at edge k; done is high and bcd_out is valid from edge k+BIN_W.
- start while busy: ignored, not queued. bin_in changes during SHIFT have no effect.
- Hold: bcd_out and overflow hold their last value until the next done or reset.
- Width rules:
  - scratch is 4*DIGITS bits;
  - the add-3 correction is 4-bit and never carries between digits;
  - the shift counter is $clog2(BIN_W) bits;
  - the overflow comparison is against the elaborated constant 10^DIGITS−1, extended to BIN_W+1 bits.
- Overflow for the defaults: BIN_W = 20 holds up to 1048575, so inputs 1000000..1048575 saturate to 999999.
- Count source: converts continuously by tying start to its update strobe. The scan driver consumes bcd_out directly, with no further division.

Decomposition:
- Shared package seg_pkg:
  - DIGIT_W = 4;
  - BCD_NINE = 4'h9;
  - state enumeration {IDLE, SHIFT};
  - function pow10(n) for the saturation limit.
- One natural sub-module, bcd_add3: 4-bit combinational "if ≥ 5 add 3". It is instantiated DIGITS times in a generate loop inside bin2bcd_seq.
- The FSM, counter and output registers stay in the top.

Test Plan:
- Reset release, then start with bin_in = 0 → done at cycle 20 after start; bcd_out = 24'h000000, overflow = 0; busy high for exactly 20 cycles.
- bin_in = 60 → bcd_out = 24'h000060, with a single done pulse.
- bin_in = 999999 → bcd_out = 24'h999999, overflow = 0. Then bin_in = 1048575 → bcd_out = 24'h999999, overflow = 1. Then bin_in = 123456 → 24'h123456, overflow back to 0.
- Busy and done-cycle starts: start held high continuously with bin_in changing every cycle → each conversion uses the value captured at acceptance, a new acceptance occurs on every done cycle, and the done period is 21 cycles.
- Reset mid-conversion: sys_rst pulsed (asynchronously, between clock edges) at shift 10 of a conversion of 54321 → bcd_out = 0 and busy = 0 immediately, no done. The next start with 54321 → 24'h054321.
- Randomised sweep of 1000 values in 0..999999 against a reference model → exact match, with one done per accepted start.
